bbox_assembler: RTL and testbench
=================================

BBOX_ASSEMBLER -- requirements
Module: bbox_assembler

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, horizontal pixel count (valid x range 0..SCREEN_W-1).
REQ-002 SHALL have parameter SCREEN_H, default 480, vertical pixel count (valid y range 0..SCREEN_H-1).
REQ-003 SHALL provide port i_clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL provide port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL provide port i_flush, input, 1 bit: synchronous abort of the partial or pending triangle.
REQ-006 SHALL provide port i_vtx_valid, input, 1 bit: vertex beat valid.
REQ-007 SHALL provide port o_vtx_ready, output, 1 bit: vertex beat accepted when valid and ready are both high.
REQ-008 SHALL provide ports i_vtx_x and i_vtx_y, input, 16 bits each: unsigned integer screen coordinates from the float-to-integer stage.
REQ-009 SHALL provide port o_bb_valid, output, 1 bit: bounding box valid.
REQ-010 SHALL provide port i_bb_ready, input, 1 bit: downstream accepts the box.
REQ-011 SHALL provide ports o_bb_xmin, o_bb_xmax, o_bb_ymin and o_bb_ymax, output, 16 bits each: clamped bounding box.
REQ-012 SHALL provide port o_bb_empty, output, 1 bit: triangle lies fully off-screen.
REQ-013 SHALL provide port o_cull, output, 1 bit: one-cycle pulse when a triangle is culled.

Function
REQ-014 SHALL implement FSM states S_V0, S_V1, S_V2 and S_OUT, with reset state S_V0.
REQ-015 SHALL drive o_vtx_ready high in S_V0, S_V1 and S_V2, and low in S_OUT.
REQ-016 SHALL advance S_V0->S_V1->S_V2 on each vertex handshake; other cycles hold state.
REQ-017 On the S_V0 handshake, SHALL load the running xmin/xmax from x and ymin/ymax from y.
REQ-018 On the S_V1 and S_V2 handshakes, SHALL update the running values with unsigned min/max.
REQ-019 On the S_V2 handshake, SHALL register the final box into the output registers and enter S_OUT; o_bb_valid goes high the next cycle (latency 1 cycle after the third vertex).
REQ-020 SHALL clamp the outputs: xmax_out = min(xmax, SCREEN_W-1) and ymax_out = min(ymax, SCREEN_H-1); xmin and ymin pass unchanged.
REQ-021 SHALL set empty = (xmin > SCREEN_W-1) or (ymin > SCREEN_H-1); when empty, all four coordinate outputs SHALL be 0.
REQ-022 In S_OUT, SHALL hold o_bb_valid and all box outputs stable until i_bb_ready is high, then return to S_V0 on the next edge.
REQ-023 SHALL reach a minimum throughput of one triangle per 4 cycles; no bypass path from S_OUT to vertex acceptance is allowed.
REQ-024 On i_flush, SHALL go to S_V0 and deassert o_bb_valid next cycle; a pending S_OUT box is dropped.
REQ-025 If i_flush coincides with a vertex handshake, flush SHALL win and the vertex is discarded.
REQ-026 A degenerate triangle (all vertices equal) SHALL yield xmin==xmax and ymin==ymax, not empty if on-screen.

Reset
REQ-027 i_rst high SHALL immediately force S_V0 and set o_bb_valid=0, o_cull=0, o_bb_empty=0 and all box outputs to 0; o_vtx_ready SHALL read 1 during and after reset.
REQ-028 Reset mid-triangle SHALL discard all partially accumulated vertices.

Configuration
REQ-029 Macro BBOX_CULL_EN defined: an empty triangle SHALL NOT enter S_OUT; the FSM returns S_V2->S_V0 and o_cull pulses for one cycle; o_bb_empty is tied 0.
REQ-030 Macro BBOX_CULL_EN undefined: an empty triangle SHALL be emitted normally with o_bb_empty=1; o_cull is tied 0.

Structure
REQ-031 Package rast_pkg SHALL hold COORD_W=16, the FSM state enum, and the box struct (xmin, xmax, ymin, ymax, empty).
REQ-032 Clamp and empty logic SHALL be a combinational sub-module bbox_clamp, parameterised by SCREEN_W and SCREEN_H.

Verification
REQ-033 Vertices (10,20),(50,5),(30,40), with i_bb_ready=1 -> box x 10..50, y 5..40, empty=0, one cycle after the third handshake.
REQ-034 Vertices (600,100),(700,470),(620,500) -> xmax=639, ymax=479, xmin=600, ymin=100, empty=0.
REQ-035 Vertices (700,10),(800,20),(900,30): without the macro -> box all zeros with empty=1; with BBOX_CULL_EN -> no o_bb_valid, o_cull pulses once, o_vtx_ready=1 the next cycle.
REQ-036 i_bb_ready held low for 5 cycles -> o_bb_valid and box stable, o_vtx_ready=0 throughout; the box is accepted on the first ready cycle.
REQ-037 Two vertices, then i_flush together with the third vertex -> no box output; the next three vertices form a fresh box.
REQ-038 i_rst asserted asynchronously in S_OUT -> o_bb_valid=0 without a clock edge; a subsequent triangle is processed correctly.

Source files
------------

// File: rtl/rast_pkg.sv
// Shared rasterizer types: coordinate width, assembler FSM states, the
// bounding-box record, and small unsigned min/max helpers.
package rast_pkg;

   localparam int COORD_W = 16;

   typedef enum logic [1:0] {
      S_V0  = 2'd0,
      S_V1  = 2'd1,
      S_V2  = 2'd2,
      S_OUT = 2'd3
   } state_t;

   typedef struct packed {
      logic [COORD_W-1:0] xmin;
      logic [COORD_W-1:0] xmax;
      logic [COORD_W-1:0] ymin;
      logic [COORD_W-1:0] ymax;
      logic               empty;
   } box_t;

   function automatic logic [COORD_W-1:0] umin(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [COORD_W-1:0] umax(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bbox_clamp.sv
// Combinational screen clamp for a raw triangle bounding box.
// Max edges are clipped to the last pixel; a box whose min corner is past
// the screen is flagged empty and reported as all-zero coordinates.
module bbox_clamp
   import rast_pkg::*;
#(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic [COORD_W-1:0] i_xmin,
   input  logic [COORD_W-1:0] i_xmax,
   input  logic [COORD_W-1:0] i_ymin,
   input  logic [COORD_W-1:0] i_ymax,
   output box_t               o_box
);

   localparam logic [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W - 1);
   localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H - 1);

   // Empty detection first; coordinates only pass through for visible boxes.
   always_comb begin
      o_box       = '0;
      o_box.empty = (i_xmin > X_LIM) || (i_ymin > Y_LIM);
      if (!o_box.empty) begin
         o_box.xmin = i_xmin;
         o_box.xmax = umin(i_xmax, X_LIM);
         o_box.ymin = i_ymin;
         o_box.ymax = umin(i_ymax, Y_LIM);
      end
   end

endmodule

// File: rtl/bbox_assembler.sv
// Triangle bounding-box assembler: collects three vertex beats, tracks the
// running unsigned min/max, clamps to the screen and presents one box.
// Optional macro BBOX_CULL_EN: off-screen triangles are dropped with a
// one-cycle o_cull pulse instead of being emitted with o_bb_empty=1.
//
// Handshakes: a vertex beat transfers on a rising edge where i_vtx_valid and
// o_vtx_ready are both high; a box transfers on a rising edge where
// o_bb_valid and i_bb_ready are both high. While o_bb_valid is high the box
// outputs do not change. i_flush overrides any transfer in the same cycle.
module bbox_assembler
   import rast_pkg::*;
#(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_flush,
   input  logic               i_vtx_valid,
   output logic               o_vtx_ready,
   input  logic [COORD_W-1:0] i_vtx_x,
   input  logic [COORD_W-1:0] i_vtx_y,
   output logic               o_bb_valid,
   input  logic               i_bb_ready,
   output logic [COORD_W-1:0] o_bb_xmin,
   output logic [COORD_W-1:0] o_bb_xmax,
   output logic [COORD_W-1:0] o_bb_ymin,
   output logic [COORD_W-1:0] o_bb_ymax,
   output logic               o_bb_empty,
   output logic               o_cull,
   output state_t             o_dbg_state
);

   state_t             state_q, state_d;
   logic [COORD_W-1:0] xmin_q, xmin_d;
   logic [COORD_W-1:0] xmax_q, xmax_d;
   logic [COORD_W-1:0] ymin_q, ymin_d;
   logic [COORD_W-1:0] ymax_q, ymax_d;
   box_t               box_q, box_d;
   box_t               clamp_box;
   logic               vtx_hs;

   assign o_vtx_ready = (state_q != S_OUT);
   assign vtx_hs      = i_vtx_valid && o_vtx_ready;

   // The third vertex is folded in combinationally so the final box is
   // registered on the same edge as its handshake.
   bbox_clamp #(
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H)
   ) u_clamp (
      .i_xmin (umin(xmin_q, i_vtx_x)),
      .i_xmax (umax(xmax_q, i_vtx_x)),
      .i_ymin (umin(ymin_q, i_vtx_y)),
      .i_ymax (umax(ymax_q, i_vtx_y)),
      .o_box  (clamp_box)
   );

`ifdef BBOX_CULL_EN
   logic cull_q, cull_d;
`endif

   // Next-state, running extents and output box; flush overrides everything.
   always_comb begin
      state_d = state_q;
      xmin_d  = xmin_q;
      xmax_d  = xmax_q;
      ymin_d  = ymin_q;
      ymax_d  = ymax_q;
      box_d   = box_q;
`ifdef BBOX_CULL_EN
      cull_d  = 1'b0;
`endif
      case (state_q)
         S_V0: begin
            if (vtx_hs) begin
               xmin_d  = i_vtx_x;
               xmax_d  = i_vtx_x;
               ymin_d  = i_vtx_y;
               ymax_d  = i_vtx_y;
               state_d = S_V1;
            end
         end
         S_V1: begin
            if (vtx_hs) begin
               xmin_d  = umin(xmin_q, i_vtx_x);
               xmax_d  = umax(xmax_q, i_vtx_x);
               ymin_d  = umin(ymin_q, i_vtx_y);
               ymax_d  = umax(ymax_q, i_vtx_y);
               state_d = S_V2;
            end
         end
         S_V2: begin
            if (vtx_hs) begin
`ifdef BBOX_CULL_EN
               if (clamp_box.empty) begin
                  cull_d  = 1'b1;
                  state_d = S_V0;
               end else begin
                  box_d   = clamp_box;
                  state_d = S_OUT;
               end
`else
               box_d   = clamp_box;
               state_d = S_OUT;
`endif
            end
         end
         S_OUT: begin
            if (i_bb_ready) begin
               state_d = S_V0;
            end
         end
         default: state_d = S_V0;
      endcase
      if (i_flush) begin
         state_d = S_V0;
         box_d   = box_q;
`ifdef BBOX_CULL_EN
         cull_d  = 1'b0;
`endif
      end
   end

   // State, extents and box registers with asynchronous clear.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_V0;
         xmin_q  <= '0;
         xmax_q  <= '0;
         ymin_q  <= '0;
         ymax_q  <= '0;
         box_q   <= '0;
      end else begin
         state_q <= state_d;
         xmin_q  <= xmin_d;
         xmax_q  <= xmax_d;
         ymin_q  <= ymin_d;
         ymax_q  <= ymax_d;
         box_q   <= box_d;
      end
   end

`ifdef BBOX_CULL_EN
   // One-cycle cull pulse register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cull_q <= 1'b0;
      end else begin
         cull_q <= cull_d;
      end
   end
   assign o_cull     = cull_q;
   assign o_bb_empty = 1'b0;
`else
   assign o_cull     = 1'b0;
   assign o_bb_empty = box_q.empty;
`endif

   assign o_bb_valid  = (state_q == S_OUT);
   assign o_bb_xmin   = box_q.xmin;
   assign o_bb_xmax   = box_q.xmax;
   assign o_bb_ymin   = box_q.ymin;
   assign o_bb_ymax   = box_q.ymax;
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_bbox_assembler.sv
// Bench for bbox_assembler: directed cases plus randomized triangles scored
// against a plain-arithmetic bounding-box model. Honours BBOX_CULL_EN.
module tb_bbox_assembler;
   import rast_pkg::*;

   localparam int SW = 640;
   localparam int SH = 480;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_flush;
   logic        i_vtx_valid;
   logic        o_vtx_ready;
   logic [15:0] i_vtx_x;
   logic [15:0] i_vtx_y;
   logic        o_bb_valid;
   logic        i_bb_ready;
   logic [15:0] o_bb_xmin;
   logic [15:0] o_bb_xmax;
   logic [15:0] o_bb_ymin;
   logic [15:0] o_bb_ymax;
   logic        o_bb_empty;
   logic        o_cull;
   state_t      o_dbg_state;

   bbox_assembler #(.SCREEN_W(SW), .SCREEN_H(SH)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_flush     (i_flush),
      .i_vtx_valid (i_vtx_valid),
      .o_vtx_ready (o_vtx_ready),
      .i_vtx_x     (i_vtx_x),
      .i_vtx_y     (i_vtx_y),
      .o_bb_valid  (o_bb_valid),
      .i_bb_ready  (i_bb_ready),
      .o_bb_xmin   (o_bb_xmin),
      .o_bb_xmax   (o_bb_xmax),
      .o_bb_ymin   (o_bb_ymin),
      .o_bb_ymax   (o_bb_ymax),
      .o_bb_empty  (o_bb_empty),
      .o_cull      (o_cull),
      .o_dbg_state (o_dbg_state)
   );

   // ---------------- clock / reset / ready driver ----------------
   always #5 i_clk = ~i_clk;

   logic rnd_en      = 1'b0;
   logic ready_force = 1'b1;
   initial i_bb_ready = 1'b1;
   always @(posedge i_clk) begin
      #2;
      i_bb_ready = rnd_en ? 1'($urandom_range(0, 1)) : ready_force;
   end

   // ---------------- scoreboard ----------------
   logic [64:0] exp_q[$];
   int checks     = 0;
   int failures   = 0;
   int boxes_exp  = 0;
   int boxes_seen = 0;
   int culls_exp  = 0;
   int culls_seen = 0;

   task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int min3(input int a, input int b, input int c);
      int m;
      m = (a < b) ? a : b;
      return (m < c) ? m : c;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Reference: {empty, xmin, xmax, ymin, ymax} from the triangle's vertices.
   function automatic logic [64:0] ref_box(input int x0, input int y0, input int x1,
                                           input int y1, input int x2, input int y2);
      int xn, xx, yn, yx;
      xn = min3(x0, x1, x2);
      xx = max3(x0, x1, x2);
      yn = min3(y0, y1, y2);
      yx = max3(y0, y1, y2);
      if (xn > SW - 1 || yn > SH - 1) return {1'b1, 64'd0};
      if (xx > SW - 1) xx = SW - 1;
      if (yx > SH - 1) yx = SH - 1;
      return {1'b0, 16'(xn), 16'(xx), 16'(yn), 16'(yx)};
   endfunction

   function automatic logic [64:0] dut_box();
      return {o_bb_empty, o_bb_xmin, o_bb_xmax, o_bb_ymin, o_bb_ymax};
   endfunction

   // Output monitor, sampled on the falling edge.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (o_cull) culls_seen++;
         if (o_bb_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_valid", 1'b1, 1'b0);
            end else begin
               check("box", dut_box(), exp_q[0]);
               check("ready_in_out", o_vtx_ready, 1'b0);
               if (i_bb_ready) begin
                  void'(exp_q.pop_front());
                  boxes_seen++;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_vtx(input int x, input int y, input int gap);
      int n;
      i_vtx_valid = 1'b0;
      repeat (gap) begin @(posedge i_clk); #1; end
      i_vtx_valid = 1'b1;
      i_vtx_x     = 16'(x);
      i_vtx_y     = 16'(y);
      n = 0;
      while (!o_vtx_ready && n < 200) begin
         @(posedge i_clk); #1;
         n++;
      end
      if (n >= 200) check("vtx_wait_timeout", 1'b0, 1'b1);
      @(posedge i_clk); #1;
      i_vtx_valid = 1'b0;
   endtask

   task automatic send_tri(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input int gap);
      logic [64:0] e;
      logic        is_cull;
      e = ref_box(x0, y0, x1, y1, x2, y2);
`ifdef BBOX_CULL_EN
      is_cull = e[64];
`else
      is_cull = 1'b0;
`endif
      if (is_cull) culls_exp++;
      else begin
         exp_q.push_back(e);
         boxes_exp++;
      end
      send_vtx(x0, y0, gap);
      send_vtx(x1, y1, gap);
      send_vtx(x2, y2, gap);
      if (is_cull) begin
         check("cull_pulse", o_cull, 1'b1);
         check("cull_no_valid", o_bb_valid, 1'b0);
         check("cull_ready", o_vtx_ready, 1'b1);
      end else begin
         check("lat_valid", o_bb_valid, 1'b1);
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !o_vtx_ready) && n < 300) begin
         @(posedge i_clk); #1;
         n++;
      end
      check("drain_timeout", (n < 300), 1'b1);
   endtask

   task automatic drop_pending();
      boxes_exp -= exp_q.size();
      exp_q.delete();
   endtask

   function automatic int rnd_coord(input int lim);
      case ($urandom_range(0, 4))
         0:       return lim - 1;
         1:       return lim;
         default: return int'($urandom_range(0, lim + 250));
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      i_rst       = 1'b1;
      i_flush     = 1'b0;
      i_vtx_valid = 1'b0;
      i_vtx_x     = '0;
      i_vtx_y     = '0;
      #3;
      check("rst_ready", o_vtx_ready, 1'b1);
      check("rst_valid", o_bb_valid, 1'b0);
      check("rst_cull", o_cull, 1'b0);
      check("rst_box", dut_box(), 65'd0);
      check("rst_state", o_dbg_state, S_V0);
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      check("post_rst_ready", o_vtx_ready, 1'b1);

      // Basic box, on-screen, then right/bottom clamping.
      send_tri(10, 20, 50, 5, 30, 40, 0);
      wait_drain();
      send_tri(600, 100, 700, 470, 620, 500, 0);
      wait_drain();
      // Fully off-screen triangle.
      send_tri(700, 10, 800, 20, 900, 30, 0);
      wait_drain();
      // Degenerate triangle and screen-corner point.
      send_tri(5, 5, 5, 5, 5, 5, 0);
      wait_drain();
      send_tri(SW - 1, SH - 1, SW - 1, SH - 1, SW - 1, SH - 1, 0);
      wait_drain();

      // Backpressure: ready low for five cycles with the box held.
      ready_force = 1'b0;
      send_tri(100, 150, 90, 160, 120, 140, 1);
      repeat (5) begin
         @(posedge i_clk); #1;
         check("stall_valid", o_bb_valid, 1'b1);
         check("stall_ready", o_vtx_ready, 1'b0);
      end
      ready_force = 1'b1;
      wait_drain();

      // Flush together with the third vertex discards the triangle.
      send_vtx(5, 6, 0);
      send_vtx(7, 8, 0);
      i_vtx_valid = 1'b1;
      i_vtx_x     = 16'd9;
      i_vtx_y     = 16'd9;
      i_flush     = 1'b1;
      @(posedge i_clk); #1;
      i_vtx_valid = 1'b0;
      i_flush     = 1'b0;
      check("flush_state", o_dbg_state, S_V0);
      check("flush_valid", o_bb_valid, 1'b0);
      send_tri(100, 200, 110, 190, 105, 210, 0);
      wait_drain();

      // Flush drops a pending box.
      ready_force = 1'b0;
      send_tri(20, 30, 40, 50, 60, 70, 0);
      i_flush = 1'b1;
      @(posedge i_clk); #1;
      i_flush = 1'b0;
      drop_pending();
      check("flush_out_valid", o_bb_valid, 1'b0);
      check("flush_out_ready", o_vtx_ready, 1'b1);
      ready_force = 1'b1;

      // Reset mid-triangle discards accumulated vertices.
      send_vtx(1, 1, 0);
      send_vtx(2, 2, 0);
      #2;
      i_rst = 1'b1;
      #1;
      check("rst_mid_state", o_dbg_state, S_V0);
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      send_tri(300, 300, 310, 320, 305, 330, 0);
      wait_drain();

      // Asynchronous reset while a box is pending.
      ready_force = 1'b0;
      send_tri(11, 12, 13, 14, 15, 16, 0);
      #2;
      i_rst = 1'b1;
      #1;
      check("arst_valid", o_bb_valid, 1'b0);
      check("arst_box", dut_box(), 65'd0);
      check("arst_ready", o_vtx_ready, 1'b1);
      drop_pending();
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      ready_force = 1'b1;
      send_tri(200, 100, 150, 50, 250, 75, 0);
      wait_drain();

      // Randomized triangles with random vertex gaps and downstream ready.
      rnd_en = 1'b1;
      for (int t = 0; t < 60; t++) begin
         send_tri(rnd_coord(SW), rnd_coord(SH), rnd_coord(SW), rnd_coord(SH),
                  rnd_coord(SW), rnd_coord(SH), int'($urandom_range(0, 2)));
      end
      rnd_en = 1'b0;
      ready_force = 1'b1;
      @(posedge i_clk); #1;
      wait_drain();

      check("box_count", 65'(boxes_seen), 65'(boxes_exp));
      check("cull_count", 65'(culls_seen), 65'(culls_exp));
      check("queue_empty", 65'(exp_q.size()), 65'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
